perf_stat_unit: RTL and testbench
=================================

Name: perf_stat_unit

Overview:
- Synthesizable, parametrised performance-statistics unit for the MIPS-lite pipeline.
- Moves instruction-class counting, stall accounting, halt detection and cycle totals out of simulation code and into RTL.
- Sits beside `main`, watches the writeback/retire stage plus hazard-unit stall strobes, and exposes counters through a registered read port with a snapshot bank.

Parameters:
- CNT_W, 32: width of every counter and of rd_data.
- SATURATE, 1: 1 = counters stick at all-ones; 0 = counters wrap modulo 2^CNT_W.
- HALT_OPC, 6'b010001: opcode that terminates the program.
- DRAIN_CYCLES, 6: pipeline fill/drain cycles added to clock totals; also the DRAIN state length.
- SEL_W, 4: width of rd_sel.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle pulse; begins counting
- retire_valid  in  1  one instruction retires this cycle
- retire_inst  in  32  retiring instruction word; opcode = [31:26]
- stall_fwd  in  1  stall cycle present with forwarding enabled
- stall_nofwd  in  1  stall cycle present with forwarding disabled
- snap  in  1  copy live counters into snapshot bank
- rd_req  in  1  read request
- rd_src  in  1  0 = live bank, 1 = snapshot bank
- rd_sel  in  SEL_W  channel select
- rd_valid  out  1  rd_data valid
- rd_data  out  CNT_W  selected channel value
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is HALTED
- ovf  out  1  sticky: some counter saturated or wrapped

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; all live and snapshot counters 0; rd_valid=0; rd_data=0; busy=0; done=0; ovf=0. Reset overrides everything, including mid-RUN or mid-DRAIN.
- FSM transitions:
  - IDLE -> RUN on start.
  - RUN -> DRAIN when retire_valid and opcode==HALT_OPC.
  - DRAIN counts DRAIN_CYCLES clocks, then goes to HALTED.
  - HALTED is terminal until reset.
  - start outside IDLE is ignored.
- Opcode classes (from [31:26]):
  - arith = 000000..000101
  - logic = 000110..001011
  - mem = 001100..001101
  - ctrl = 001110..010001 (HALT counts as ctrl)
  - all other opcodes are counted in no class and raise no flag.
- Counting rules:
  - Retire and stall events count only in RUN.
  - The HALT retire itself counts.
  - Inputs in IDLE, DRAIN and HALTED are ignored.
  - The cycles counter increments every clock in RUN and DRAIN.
- Counter updates take effect at the clock edge; the new value is readable one cycle later.
- Saturation/overflow:
  - SATURATE=1: a counter at all-ones holds and sets ovf.
  - SATURATE=0: a counter wraps to 0 and sets ovf.
  - ovf is cleared only by reset.
- Channel map (rd_sel):
  - 0 arith; 1 logic; 2 mem; 3 ctrl
  - 4 total_inst = sum of channels 0-3
  - 5 stall_fwd count; 6 stall_nofwd count
  - 7 clk_w_fwd = total_inst + DRAIN_CYCLES + ch5
  - 8 clk_wo_fwd = total_inst + DRAIN_CYCLES + ch6
  - 9 cycles
  - 10..2^SEL_W-1 return 0
  - Derived channels 4, 7, 8 are computed at CNT_W width and follow the SATURATE mode (clamped or truncated).
  - Each bank (live and snapshot) stores only the seven primaries; derived values are computed from the selected bank.
- Read port:
  - rd_req at edge N gives rd_valid=1 with rd_data during cycle N+1.
  - rd_valid is a single-cycle pulse per request; back-to-back requests give back-to-back data.
  - Without rd_req, rd_valid=0 and rd_data holds its last value.
- Snapshot:
  - snap at edge N copies the pre-update live values (values before edge N's increments).
  - snap and rd_req(rd_src=1) in the same cycle return the old snapshot.
  - snap is accepted in every state except reset.

Decomposition:
- Shared package `perf_pkg`:
  - opcode localparams (ADD..HALT)
  - enum inst_class_t {CLS_ARITH, CLS_LOGIC, CLS_MEM, CLS_CTRL, CLS_NONE}
  - enum perf_state_t {IDLE, RUN, DRAIN, HALTED}
  - channel-index localparams CH_ARITH..CH_CYCLES
  - function classify(opcode) returning inst_class_t
- One sub-module: `perf_counter`, a CNT_W-wide counter with increment enable, SATURATE mode and an overflow pulse; instantiated seven times.

Test Plan:
1. Nominal run:
   - Stimulus: reset, start; retire ADD×3, ORI×2, LDW, BEQ, HALT; stall_fwd 2 cycles, stall_nofwd 5 cycles.
   - Response: ch0..ch8 read 3, 2, 1, 2, 8, 2, 5, 16, 19; busy falls and done rises exactly 6 cycles after the HALT retire edge.
2. Saturation and wrap:
   - Stimulus: CNT_W=4, SATURATE=1, 20 ADDs.
   - Response: arith=15, ovf=1. Rerun with SATURATE=0: arith=4, ovf=1.
3. Snap race:
   - Stimulus: after 5 ADDs, snap in the same cycle as a 6th ADD retire.
   - Response: snapshot ch0=5, live ch0=6, snapshot ch4=5.
4. Post-halt and pre-start inputs:
   - Stimulus: retire_valid, stall_fwd and stall_nofwd pulses in IDLE and in HALTED.
   - Response: all counters unchanged; start in HALTED leaves done=1.
5. Mid-run reset:
   - Stimulus: reset low for one edge during RUN with counters nonzero.
   - Response: next cycle state=IDLE, all reads 0, busy=0, done=0, ovf=0.
6. Read port:
   - Stimulus: rd_req with rd_sel=12, then back-to-back rd_req on sel 0 and 9.
   - Response: rd_valid exactly one cycle after each request; data 0, then arith, then cycles; rd_valid=0 when idle.

Source files
------------

// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared opcodes, classes, states and channel map for perf_stat_unit
package perf_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_MUL  = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b000011;
    localparam logic [5:0] OP_SUBI = 6'b000100;
    localparam logic [5:0] OP_MULI = 6'b000101;
    localparam logic [5:0] OP_OR   = 6'b000110;
    localparam logic [5:0] OP_AND  = 6'b000111;
    localparam logic [5:0] OP_XOR  = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001001;
    localparam logic [5:0] OP_ANDI = 6'b001010;
    localparam logic [5:0] OP_XORI = 6'b001011;
    localparam logic [5:0] OP_LDW  = 6'b001100;
    localparam logic [5:0] OP_STW  = 6'b001101;
    localparam logic [5:0] OP_BZ   = 6'b001110;
    localparam logic [5:0] OP_BEQ  = 6'b001111;
    localparam logic [5:0] OP_JR   = 6'b010000;
    localparam logic [5:0] OP_HALT = 6'b010001;

    // Primary counters held in each bank
    localparam int NUM_PRIM    = 7;
    localparam int PRIM_ARITH  = 0;
    localparam int PRIM_LOGIC  = 1;
    localparam int PRIM_MEM    = 2;
    localparam int PRIM_CTRL   = 3;
    localparam int PRIM_SFWD   = 4;
    localparam int PRIM_SNOFWD = 5;
    localparam int PRIM_CYC    = 6;

    // Read channel map
    localparam int unsigned CH_ARITH      = 0;
    localparam int unsigned CH_LOGIC      = 1;
    localparam int unsigned CH_MEM        = 2;
    localparam int unsigned CH_CTRL       = 3;
    localparam int unsigned CH_TOTAL      = 4;
    localparam int unsigned CH_STALL_FWD  = 5;
    localparam int unsigned CH_STALL_NFWD = 6;
    localparam int unsigned CH_CLK_W_FWD  = 7;
    localparam int unsigned CH_CLK_WO_FWD = 8;
    localparam int unsigned CH_CYCLES     = 9;

    typedef enum logic [2:0] {CLS_ARITH, CLS_LOGIC, CLS_MEM, CLS_CTRL, CLS_NONE} inst_class_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} perf_state_t;

    function automatic inst_class_t classify(input logic [5:0] opcode);
        inst_class_t cls;
        case (opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_ADDI, OP_SUBI, OP_MULI: cls = CLS_ARITH;
            OP_OR, OP_AND, OP_XOR, OP_ORI, OP_ANDI, OP_XORI:   cls = CLS_LOGIC;
            OP_LDW, OP_STW:                                    cls = CLS_MEM;
            OP_BZ, OP_BEQ, OP_JR, OP_HALT:                     cls = CLS_CTRL;
            default:                                           cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/perf_stat_unit_if.sv
// rtl/perf_stat_unit_if.sv - counter read port bundle
interface perf_stat_unit_if #(
    parameter int CNT_W = 32,
    parameter int SEL_W = 4
);
    logic             rd_req;
    logic             rd_src;
    logic [SEL_W-1:0] rd_sel;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;

    modport master (output rd_req, rd_src, rd_sel, input rd_valid, rd_data);
    modport slave  (input rd_req, rd_src, rd_sel, output rd_valid, rd_data);
endinterface

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - event counter with saturate or wrap mode and overflow pulse
module perf_counter #(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             ovf_pulse
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: at all-ones either hold or wrap, flagging overflow either way
    always_comb begin
        count_d   = count_q;
        ovf_pulse = 1'b0;
        if (inc) begin
            if (&count_q) begin
                ovf_pulse = 1'b1;
                count_d   = SATURATE ? count_q : '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/perf_stat_unit.sv
// rtl/perf_stat_unit.sv - retire/stall statistics with live and snapshot banks
module perf_stat_unit
    import perf_pkg::*;
#(
    parameter int         CNT_W        = 32,
    parameter bit         SATURATE     = 1'b1,
    parameter logic [5:0] HALT_OPC     = 6'b010001,
    parameter int         DRAIN_CYCLES = 6,
    parameter int         SEL_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               retire_valid,
    input  logic [31:0]        retire_inst,
    input  logic               stall_fwd,
    input  logic               stall_nofwd,
    input  logic               snap,
    perf_stat_unit_if.slave    rd,
    output logic               busy,
    output logic               done,
    output logic               ovf
);

    // Derived sums need headroom for five counters plus the drain constant
    localparam int WW      = CNT_W + 3;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    perf_state_t        state_q, state_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic               ovf_q, ovf_d;
    logic               rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]   rd_data_q, rd_data_d;
    logic [CNT_W-1:0]   snap_q [NUM_PRIM];
    logic [CNT_W-1:0]   snap_d [NUM_PRIM];

    logic [CNT_W-1:0]   live [NUM_PRIM];
    logic [CNT_W-1:0]   bank [NUM_PRIM];
    logic [NUM_PRIM-1:0] inc;
    logic [NUM_PRIM-1:0] ovf_p;
    logic [WW-1:0]      total_w, clkf_w, clknf_w;
    logic [31:0]        sel_i;
    inst_class_t        ret_cls;
    logic               retire_halt;
    logic               unused_inst_bits;

    assign ret_cls          = classify(retire_inst[31:26]);
    assign retire_halt      = retire_valid && (retire_inst[31:26] == HALT_OPC);
    assign unused_inst_bits = ^retire_inst[25:0];

    function automatic logic [CNT_W-1:0] fit(input logic [WW-1:0] v);
        logic [CNT_W-1:0] r;
        if (SATURATE && (v > WW'({CNT_W{1'b1}}))) begin
            r = '1;
        end else begin
            r = v[CNT_W-1:0];
        end
        return r;
    endfunction

    // Run-state sequencing: IDLE -> RUN -> fixed-length DRAIN -> HALTED
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (retire_halt) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_d = HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // Increment enables: events only while running, cycles through the drain as well
    always_comb begin
        inc = '0;
        if (state_q == RUN) begin
            if (retire_valid) begin
                case (ret_cls)
                    CLS_ARITH: inc[PRIM_ARITH] = 1'b1;
                    CLS_LOGIC: inc[PRIM_LOGIC] = 1'b1;
                    CLS_MEM:   inc[PRIM_MEM]   = 1'b1;
                    CLS_CTRL:  inc[PRIM_CTRL]  = 1'b1;
                    default:   ;
                endcase
            end
            inc[PRIM_SFWD]   = stall_fwd;
            inc[PRIM_SNOFWD] = stall_nofwd;
        end
        if ((state_q == RUN) || (state_q == DRAIN)) begin
            inc[PRIM_CYC] = 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_PRIM; k++) begin : g_cnt
        perf_counter #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc[k]),
            .count     (live[k]),
            .ovf_pulse (ovf_p[k])
        );
    end

    // Snapshot takes the live values as they stood before this edge's increments
    always_comb begin
        for (int k = 0; k < NUM_PRIM; k++) begin
            snap_d[k] = snap ? live[k] : snap_q[k];
        end
        ovf_d = ovf_q | (|ovf_p);
    end

    // Bank select and derived channels, summed wide then clamped or truncated
    always_comb begin
        for (int k = 0; k < NUM_PRIM; k++) begin
            bank[k] = rd.rd_src ? snap_q[k] : live[k];
        end
        total_w = WW'(bank[PRIM_ARITH]) + WW'(bank[PRIM_LOGIC])
                + WW'(bank[PRIM_MEM])   + WW'(bank[PRIM_CTRL]);
        clkf_w  = total_w + WW'(DRAIN_CYCLES) + WW'(bank[PRIM_SFWD]);
        clknf_w = total_w + WW'(DRAIN_CYCLES) + WW'(bank[PRIM_SNOFWD]);
    end

    // Read response: one-cycle valid pulse, data held between requests
    always_comb begin
        sel_i      = 32'(rd.rd_sel);
        rd_valid_d = rd.rd_req;
        rd_data_d  = rd_data_q;
        if (rd.rd_req) begin
            case (sel_i)
                CH_ARITH:      rd_data_d = bank[PRIM_ARITH];
                CH_LOGIC:      rd_data_d = bank[PRIM_LOGIC];
                CH_MEM:        rd_data_d = bank[PRIM_MEM];
                CH_CTRL:       rd_data_d = bank[PRIM_CTRL];
                CH_TOTAL:      rd_data_d = fit(total_w);
                CH_STALL_FWD:  rd_data_d = bank[PRIM_SFWD];
                CH_STALL_NFWD: rd_data_d = bank[PRIM_SNOFWD];
                CH_CLK_W_FWD:  rd_data_d = fit(clkf_w);
                CH_CLK_WO_FWD: rd_data_d = fit(clknf_w);
                CH_CYCLES:     rd_data_d = bank[PRIM_CYC];
                default:       rd_data_d = '0;
            endcase
        end
    end

    // Control, snapshot and read registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            ovf_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            for (int k = 0; k < NUM_PRIM; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            ovf_q       <= ovf_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            for (int k = 0; k < NUM_PRIM; k++) begin
                snap_q[k] <= snap_d[k];
            end
        end
    end

    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_data  = rd_data_q;
    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign done        = (state_q == HALTED);
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_perf_stat_unit.sv
// tb/tb_perf_stat_unit.sv - scoreboard bench for perf_stat_unit
module tb_perf_stat_unit;
    import perf_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, retire_valid, stall_fwd, stall_nofwd, snap;
    logic        rd_req, rd_src;
    logic [3:0]  rd_sel;
    logic [31:0] retire_inst;
    logic [2:0]  busy_v, done_v, ovf_v, rv;
    logic [63:0] rdat [3];

    always #5 clk = ~clk;

    perf_stat_unit_if #(.CNT_W(32), .SEL_W(4)) bus_a ();
    perf_stat_unit_if #(.CNT_W(4),  .SEL_W(4)) bus_b ();
    perf_stat_unit_if #(.CNT_W(4),  .SEL_W(4)) bus_c ();

    assign bus_a.rd_req = rd_req; assign bus_a.rd_src = rd_src; assign bus_a.rd_sel = rd_sel;
    assign bus_b.rd_req = rd_req; assign bus_b.rd_src = rd_src; assign bus_b.rd_sel = rd_sel;
    assign bus_c.rd_req = rd_req; assign bus_c.rd_src = rd_src; assign bus_c.rd_sel = rd_sel;
    assign rv      = {bus_c.rd_valid, bus_b.rd_valid, bus_a.rd_valid};
    assign rdat[0] = 64'(bus_a.rd_data);
    assign rdat[1] = 64'(bus_b.rd_data);
    assign rdat[2] = 64'(bus_c.rd_data);

    perf_stat_unit #(.CNT_W(32), .SATURATE(1'b1), .HALT_OPC(6'b010001), .DRAIN_CYCLES(6), .SEL_W(4)) dut_a (
        .clk(clk), .reset(reset), .start(start), .retire_valid(retire_valid), .retire_inst(retire_inst),
        .stall_fwd(stall_fwd), .stall_nofwd(stall_nofwd), .snap(snap), .rd(bus_a),
        .busy(busy_v[0]), .done(done_v[0]), .ovf(ovf_v[0]));
    perf_stat_unit #(.CNT_W(4), .SATURATE(1'b1), .HALT_OPC(6'b010001), .DRAIN_CYCLES(6), .SEL_W(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .retire_valid(retire_valid), .retire_inst(retire_inst),
        .stall_fwd(stall_fwd), .stall_nofwd(stall_nofwd), .snap(snap), .rd(bus_b),
        .busy(busy_v[1]), .done(done_v[1]), .ovf(ovf_v[1]));
    perf_stat_unit #(.CNT_W(4), .SATURATE(1'b0), .HALT_OPC(6'b010001), .DRAIN_CYCLES(6), .SEL_W(4)) dut_c (
        .clk(clk), .reset(reset), .start(start), .retire_valid(retire_valid), .retire_inst(retire_inst),
        .stall_fwd(stall_fwd), .stall_nofwd(stall_nofwd), .snap(snap), .rd(bus_c),
        .busy(busy_v[2]), .done(done_v[2]), .ovf(ovf_v[2]));

    // Reference model: unbounded event counts; width/mode applied when a value is read
    longint live_m [7];
    longint snap_m [7];
    int     ms;          // 0 idle, 1 run, 2 drain, 3 halted
    int     drain_left;
    longint q [3][$];
    logic [63:0] last [3];
    logic [63:0] mon_e;
    bit     mon_en = 1'b0;
    int     n_checks = 0;
    int     n_pass = 0;

    function automatic int dw(int i);
        return (i == 0) ? 32 : 4;
    endfunction

    function automatic bit ds(int i);
        return (i != 2);
    endfunction

    function automatic longint fitv(longint v, int w, bit s);
        longint m;
        m = (longint'(1) << w) - 1;
        if (s) return (v > m) ? m : v;
        return v & m;
    endfunction

    function automatic int cls_of(int op);
        if (op <= 5)  return 0;
        if (op <= 11) return 1;
        if (op <= 13) return 2;
        if (op <= 17) return 3;
        return -1;
    endfunction

    function automatic longint chan_exp(bit src, int sel, int w, bit s);
        longint b [7];
        longint tot;
        for (int k = 0; k < 7; k++) b[k] = src ? snap_m[k] : live_m[k];
        tot = b[0] + b[1] + b[2] + b[3];
        case (sel)
            0, 1, 2, 3: return fitv(b[sel], w, s);
            4:          return fitv(tot, w, s);
            5:          return fitv(b[4], w, s);
            6:          return fitv(b[5], w, s);
            7:          return fitv(tot + 6 + b[4], w, s);
            8:          return fitv(tot + 6 + b[5], w, s);
            9:          return fitv(b[6], w, s);
            default:    return 0;
        endcase
    endfunction

    function automatic bit ovf_exp(int w);
        longint m;
        m = (longint'(1) << w) - 1;
        for (int k = 0; k < 7; k++) if (live_m[k] > m) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", nm, act, exp);
    endtask

    task automatic model_edge();
        int c;
        if (!reset) begin
            for (int k = 0; k < 7; k++) begin live_m[k] = 0; snap_m[k] = 0; end
            ms = 0; drain_left = 0;
            for (int i = 0; i < 3; i++) last[i] = '0;
        end else begin
            if (snap) for (int k = 0; k < 7; k++) snap_m[k] = live_m[k];
            case (ms)
                0: if (start) ms = 1;
                1: begin
                    live_m[6]++;
                    if (retire_valid) begin
                        c = cls_of(int'(retire_inst[31:26]));
                        if (c >= 0) live_m[c]++;
                        if (retire_inst[31:26] == 6'd17) begin ms = 2; drain_left = 6; end
                    end
                    if (stall_fwd)   live_m[4]++;
                    if (stall_nofwd) live_m[5]++;
                end
                2: begin
                    live_m[6]++;
                    drain_left--;
                    if (drain_left == 0) ms = 3;
                end
                default: ;
            endcase
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b1; start = 1'b0; retire_valid = 1'b0; retire_inst = '0;
        stall_fwd = 1'b0; stall_nofwd = 1'b0; snap = 1'b0;
        rd_req = 1'b0; rd_src = 1'b0; rd_sel = '0;
    endtask

    // One clock: record expected read (pre-edge view), advance model, check status outputs
    task automatic tick();
        longint pend [3];
        bit have;
        have = rd_req;
        if (have) for (int i = 0; i < 3; i++) pend[i] = chan_exp(rd_src, int'(rd_sel), dw(i), ds(i));
        @(posedge clk);
        if (have) for (int i = 0; i < 3; i++) q[i].push_back(pend[i]);
        model_edge();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy[%0d]", i), 64'(busy_v[i]), 64'(ms == 1 || ms == 2));
            chk($sformatf("done[%0d]", i), 64'(done_v[i]), 64'(ms == 3));
            chk($sformatf("ovf[%0d]", i),  64'(ovf_v[i]),  64'(ovf_exp(dw(i))));
        end
        idle_inputs();
    endtask

    task automatic set_ret(input logic [5:0] op);
        retire_valid = 1'b1;
        retire_inst  = {op, 26'($urandom)};
    endtask

    task automatic rd(input bit src, input int sel);
        rd_req = 1'b1; rd_src = src; rd_sel = 4'(sel);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
    endtask

    task automatic read_all();
        for (int s = 0; s < 16; s++) rd(1'b0, s);
        for (int s = 0; s < 10; s++) rd(1'b1, s);
    endtask

    // Monitor: every response popped against the scoreboard; data held between responses
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                if (rv[i]) begin
                    if (q[i].size() == 0) begin
                        n_checks++;
                        $display("FAIL rd_valid_unexpected[%0d]: got 1 required 0", i);
                    end else begin
                        mon_e = 64'(q[i].pop_front());
                        chk($sformatf("rd_data[%0d]", i), rdat[i], mon_e);
                        last[i] = mon_e;
                    end
                end else begin
                    if (q[i].size() != 0) begin
                        n_checks++;
                        $display("FAIL rd_valid_missing[%0d]: got 0 required 1", i);
                        void'(q[i].pop_front());
                    end
                    chk($sformatf("rd_hold[%0d]", i), rdat[i], last[i]);
                end
            end
        end
    end

    initial begin
        int op;
        idle_inputs();
        for (int k = 0; k < 7; k++) begin live_m[k] = 0; snap_m[k] = 0; end
        ms = 0; drain_left = 0;
        for (int i = 0; i < 3; i++) last[i] = '0;
        @(negedge clk);
        do_reset();
        mon_en = 1'b1;
        read_all();

        // Pre-start inputs ignored, then the nominal program
        set_ret(OP_ADD); stall_fwd = 1'b1; stall_nofwd = 1'b1; tick();
        start = 1'b1; tick();
        set_ret(OP_ADD); stall_fwd = 1'b1; tick();
        set_ret(OP_ADD); stall_fwd = 1'b1; tick();
        set_ret(OP_ADD); stall_nofwd = 1'b1; tick();
        set_ret(OP_ORI); stall_nofwd = 1'b1; tick();
        set_ret(OP_ORI); tick();
        set_ret(OP_LDW); stall_nofwd = 1'b1; tick();
        set_ret(OP_BEQ); stall_nofwd = 1'b1; tick();
        stall_nofwd = 1'b1; start = 1'b1; tick();
        set_ret(OP_HALT); tick();
        for (int n = 0; n < 8; n++) tick();
        // Inputs in HALTED ignored, start leaves done asserted
        set_ret(OP_ADD); stall_fwd = 1'b1; stall_nofwd = 1'b1; start = 1'b1; tick();
        set_ret(OP_HALT); snap = 1'b1; tick();
        read_all();

        // Mid-run reset
        do_reset();
        start = 1'b1; tick();
        for (int n = 0; n < 4; n++) begin set_ret(OP_XOR); stall_fwd = 1'b1; tick(); end
        snap = 1'b1; tick();
        do_reset();
        read_all();

        // Saturation / wrap on the narrow instances
        start = 1'b1; tick();
        for (int n = 0; n < 20; n++) begin set_ret(OP_ADD); tick(); end
        rd(1'b0, 0); rd(1'b0, 4); rd(1'b0, 7); rd(1'b0, 9);

        // Snap racing a retire and a snapshot read
        do_reset();
        start = 1'b1; tick();
        for (int n = 0; n < 5; n++) begin set_ret(OP_ADD); tick(); end
        set_ret(OP_ADD); snap = 1'b1; rd_req = 1'b1; rd_src = 1'b1; rd_sel = 4'd0; tick();
        rd(1'b1, 0); rd(1'b0, 0); rd(1'b1, 4);

        // Read port: out-of-map channel then back-to-back requests
        tick();
        rd(1'b0, 12);
        tick();
        rd(1'b0, 0); rd(1'b0, 9);
        tick(); tick();

        // Randomised runs
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int n = 0; n < 3; n++) begin
                retire_valid = 1'($urandom); retire_inst = $urandom;
                stall_fwd = 1'($urandom); stall_nofwd = 1'($urandom); tick();
            end
            start = 1'b1; tick();
            for (int n = 0; n < 70; n++) begin
                op = int'($urandom_range(0, 63));
                if (op == 17 && ($urandom_range(0, 3) != 0)) op = 18;
                if ($urandom_range(0, 1) != 0) set_ret(6'(op));
                stall_fwd   = ($urandom_range(0, 3) == 0);
                stall_nofwd = ($urandom_range(0, 2) == 0);
                snap        = ($urandom_range(0, 7) == 0);
                start       = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 1) != 0) begin
                    rd_req = 1'b1; rd_src = 1'($urandom); rd_sel = 4'($urandom);
                end
                tick();
            end
            set_ret(OP_HALT); tick();
            for (int n = 0; n < 8; n++) tick();
            read_all();
        end

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
